// File: rtl/video_pkg.sv
// Shared types and constants for the video nibble feeder.
package video_pkg;

   localparam int unsigned LOAD_PERIOD = 4;
   localparam int unsigned FIFO_DEPTH  = 2;
   localparam int unsigned PHASE_W     = 2;
   localparam int unsigned FCNT_W      = 2;
   localparam int unsigned BYTE_W      = 8;
   localparam int unsigned NIB_W       = 4;

   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} line_state_e;
   typedef enum logic {F_IDLE, F_WAIT} fetch_state_e;

   // Display byte as seen by the nibble selector.
   typedef struct packed {
      logic [NIB_W-1:0] hi;
      logic [NIB_W-1:0] lo;
   } video_byte_t;

endpackage

// File: rtl/nibble_fifo2.sv
// Two-entry byte FIFO between the video RAM fetcher and the nibble loader.
module nibble_fifo2
   import video_pkg::*;
(
   input  logic              clk_i,
   input  logic              clrn_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [BYTE_W-1:0] din_i,
   output logic [FCNT_W-1:0] count_o,
   output logic [BYTE_W-1:0] head_o
);

   logic [BYTE_W-1:0] head_q;
   logic [BYTE_W-1:0] tail_q;
   logic [FCNT_W-1:0] count_q;
   logic              pop_ok;
   logic              push_ok;

   // Pop on empty is dropped; a push at full is taken only alongside a pop.
   always_comb begin
      pop_ok  = pop_i && (count_q != '0);
      push_ok = push_i && ((count_q < FCNT_W'(FIFO_DEPTH)) || pop_ok);
   end

   // Entries shift toward the head; count tracks occupancy.
   always_ff @(posedge clk_i or negedge clrn_i) begin
      if (!clrn_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10: begin
               if (count_q == '0) head_q <= din_i;
               else               tail_q <= din_i;
               count_q <= count_q + FCNT_W'(1);
            end
            2'b01: begin
               head_q  <= tail_q;
               count_q <= count_q - FCNT_W'(1);
            end
            2'b11: begin
               if (count_q == FCNT_W'(1)) begin
                  head_q <= din_i;
               end else begin
                  head_q <= tail_q;
                  tail_q <= din_i;
               end
            end
            default: ;
         endcase
      end
   end

   assign count_o = count_q;
   assign head_o  = head_q;

endmodule

// File: rtl/video_nibble_feeder.sv
// Fetches display bytes and feeds them as nibbles to a 4-bit PISO shift register.
module video_nibble_feeder
   import video_pkg::*;
#(
   parameter int unsigned NIBBLES_PER_LINE = 32,
   parameter int unsigned ADDR_W           = 16
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              line_start,
   input  logic [ADDR_W-1:0] line_base,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [7:0]        mem_data,
   output logic              sh_ldn,
   output logic              j,
   output logic              kn,
   output logic              a,
   output logic              b,
   output logic              c,
   output logic              d,
   output logic              active,
   output logic              line_done,
   output logic              underrun
);

   localparam int unsigned CNT_W = 9;
   localparam int unsigned HALF  = NIBBLES_PER_LINE / 2;

   line_state_e       line_q;
   fetch_state_e      fetch_q;
   logic [PHASE_W-1:0] phase_q;
   logic [CNT_W-1:0]  loads_q;
   logic [CNT_W-1:0]  bytes_req_q;
   logic              hi_sel_q;
   logic [ADDR_W-1:0] base_q;
   logic [NIB_W-1:0]  nib_q;
   logic              sh_ldn_q;
   logic              active_q;
   logic              line_done_q;
   logic              underrun_q;
   logic              mem_req_q;
   logic [ADDR_W-1:0] mem_addr_q;

   logic              start_c;
   logic              load_c;
   logic              push_c;
   logic              pop_c;
   logic              fetch_go_c;
   logic [FCNT_W-1:0] fifo_count;
   video_byte_t       fifo_head;

   // Shared strobes: line accept, load edge, FIFO traffic and fetch permission.
   always_comb begin
      start_c    = (line_q == IDLE) && line_start;
      load_c     = (line_q == ACTIVE) && (phase_q == PHASE_W'(LOAD_PERIOD - 2));
      push_c     = (fetch_q == F_WAIT) && mem_ack;
      pop_c      = load_c && hi_sel_q;
      fetch_go_c = (start_c || (active_q && (bytes_req_q < CNT_W'(HALF))))
                   && (fifo_count < FCNT_W'(FIFO_DEPTH));
   end

   nibble_fifo2 u_fifo (
      .clk_i   (clk),
      .clrn_i  (clrn),
      .push_i  (push_c),
      .pop_i   (pop_c),
      .din_i   (mem_data),
      .count_o (fifo_count),
      .head_o  (fifo_head)
   );

   // Line sequencer: one load every LOAD_PERIOD clocks, then a short drain.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         line_q      <= IDLE;
         phase_q     <= '0;
         loads_q     <= '0;
         hi_sel_q    <= 1'b0;
         base_q      <= '0;
         nib_q       <= '0;
         sh_ldn_q    <= 1'b1;
         active_q    <= 1'b0;
         line_done_q <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         sh_ldn_q    <= 1'b1;
         line_done_q <= 1'b0;
         case (line_q)
            IDLE: begin
               if (line_start) begin
                  base_q     <= line_base;
                  phase_q    <= '0;
                  loads_q    <= '0;
                  hi_sel_q   <= 1'b0;
                  underrun_q <= 1'b0;
                  active_q   <= 1'b1;
                  line_q     <= ACTIVE;
               end
            end
            ACTIVE: begin
               phase_q <= phase_q + PHASE_W'(1);
               if (load_c) begin
                  sh_ldn_q <= 1'b0;
                  loads_q  <= loads_q + CNT_W'(1);
                  hi_sel_q <= ~hi_sel_q;
                  if (fifo_count == '0) begin
                     nib_q      <= '0;
                     underrun_q <= 1'b1;
                  end else begin
                     nib_q <= hi_sel_q ? fifo_head.hi : fifo_head.lo;
                  end
               end
               if ((phase_q == PHASE_W'(LOAD_PERIOD - 1)) &&
                   (loads_q == CNT_W'(NIBBLES_PER_LINE))) begin
                  line_q <= DRAIN;
               end
            end
            DRAIN: begin
               phase_q <= phase_q + PHASE_W'(1);
               if (phase_q == PHASE_W'(LOAD_PERIOD - 1)) begin
                  line_done_q <= 1'b1;
                  active_q    <= 1'b0;
                  line_q      <= IDLE;
               end
            end
            default: line_q <= IDLE;
         endcase
      end
   end

   // Fetcher: at most one outstanding byte request, gated by FIFO room.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         fetch_q     <= F_IDLE;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         bytes_req_q <= '0;
      end else begin
         if (start_c)     bytes_req_q <= '0;
         else if (push_c) bytes_req_q <= bytes_req_q + CNT_W'(1);
         case (fetch_q)
            F_IDLE: begin
               if (fetch_go_c) begin
                  mem_req_q  <= 1'b1;
                  mem_addr_q <= start_c ? line_base : (base_q + ADDR_W'(bytes_req_q));
                  fetch_q    <= F_WAIT;
               end
            end
            F_WAIT: begin
               if (mem_ack) begin
                  mem_req_q <= 1'b0;
                  fetch_q   <= F_IDLE;
               end
            end
            default: fetch_q <= F_IDLE;
         endcase
      end
   end

   assign mem_req      = mem_req_q;
   assign mem_addr     = mem_addr_q;
   assign sh_ldn       = sh_ldn_q;
   assign j            = 1'b0;
   assign kn           = 1'b0;
   assign {a, b, c, d} = nib_q;
   assign active       = active_q;
   assign line_done    = line_done_q;
   assign underrun     = underrun_q;

endmodule

// File: tb/tb_video_nibble_feeder.sv
// Bench for video_nibble_feeder: memory responder plus a queue-based line model.
module tb_video_nibble_feeder;

   localparam int unsigned NPL = 4;
   localparam int unsigned AW  = 16;

   logic          clk = 1'b0;
   logic          clrn = 1'b0;
   logic          line_start = 1'b0;
   logic [AW-1:0] line_base = '0;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_ack = 1'b0;
   logic [7:0]    mem_data = '0;
   logic          sh_ldn, j, kn, a, b, c, d, active, line_done, underrun;

   logic          f_push = 1'b0;
   logic          f_pop = 1'b0;
   logic [7:0]    f_din = '0;
   logic [1:0]    f_count;
   logic [7:0]    f_head;

   int            vectors = 0;
   int            miscompares = 0;
   int            cyc = 0;
   int            lat = 1;
   int            wcnt = 0;
   logic          mem_pend = 1'b0;

   logic [7:0]    ram [int unsigned];
   logic [7:0]    push_dat [$];
   int            push_t [$];
   int            rd_ptr = 0;
   logic [AW-1:0] addr_log [$];
   logic [3:0]    last_nib = '0;
   logic [3:0]    obs_ld [$];
   int            done_cnt, done_rel, load_cnt, addr_idx0;
   logic [7:0]    fq [$];

   video_nibble_feeder #(.NIBBLES_PER_LINE(NPL), .ADDR_W(AW)) dut (
      .clk(clk), .clrn(clrn), .line_start(line_start), .line_base(line_base),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
      .sh_ldn(sh_ldn), .j(j), .kn(kn), .a(a), .b(b), .c(c), .d(d),
      .active(active), .line_done(line_done), .underrun(underrun)
   );

   nibble_fifo2 fifo_u (
      .clk_i(clk), .clrn_i(clrn), .push_i(f_push), .pop_i(f_pop),
      .din_i(f_din), .count_o(f_count), .head_o(f_head)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   function automatic logic [7:0] ram_rd(input logic [AW-1:0] ad);
      if (!ram.exists(32'(ad))) ram[32'(ad)] = 8'($urandom);
      return ram[32'(ad)];
   endfunction

   // Video RAM: acks each request lat clocks after it is raised; logs pushes.
   initial begin
      forever begin
         @(negedge clk);
         if (!clrn) begin
            mem_ack  = 1'b0;
            mem_pend = 1'b0;
         end else if (mem_ack) begin
            mem_ack  = 1'b0;
            mem_pend = 1'b0;
         end else if (mem_req) begin
            if (!mem_pend) begin
               mem_pend = 1'b1;
               wcnt     = lat;
               addr_log.push_back(mem_addr);
            end
            wcnt--;
            if (wcnt <= 0) begin
               mem_data = ram_rd(mem_addr);
               mem_ack  = 1'b1;
               push_dat.push_back(mem_data);
               push_t.push_back(cyc + 1);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic model_clear();
      push_dat.delete();
      push_t.delete();
      addr_log.delete();
      rd_ptr   = 0;
      last_nib = '0;
   endtask

   // Runs one line and checks every cycle against the queue model.
   task automatic do_line(input logic [AW-1:0] base, input int l, input int spur);
      int t0, e, k, navail;
      logic exp_und, is_ld;
      logic [3:0] nib;
      logic [7:0] byt;
      logic [9:0] exp_v, act_v;
      lat = l;
      obs_ld.delete();
      done_cnt = 0; done_rel = -1; load_cnt = 0;
      addr_idx0 = addr_log.size();
      @(negedge clk);
      line_base  = base;
      line_start = 1'b1;
      @(negedge clk);
      line_start = 1'b0;
      t0 = cyc;
      exp_und = 1'b0;
      for (int rel = 0; rel <= 4 * NPL + 8; rel++) begin
         if (rel > 0) @(negedge clk);
         e = cyc;
         is_ld = (rel % 4 == 3) && (rel < 4 * NPL);
         if (is_ld) begin
            k = rel / 4;
            navail = 0;
            foreach (push_t[i]) if (push_t[i] < e) navail++;
            if (rd_ptr < navail) begin
               byt = push_dat[rd_ptr];
               nib = (k % 2 == 1) ? byt[7:4] : byt[3:0];
               if (k % 2 == 1) rd_ptr++;
            end else begin
               nib = 4'h0;
               exp_und = 1'b1;
            end
            last_nib = nib;
         end
         exp_v = {~is_ld, last_nib, (rel <= 4 * NPL + 3), (rel == 4 * NPL + 4), exp_und, 2'b00};
         act_v = {sh_ldn, a, b, c, d, active, line_done, underrun, j, kn};
         vectors++;
         if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL line_vec base=%h rel=%0d got=%b exp=%b (sh_ldn,abcd,active,done,underrun,j,kn)",
                     base, rel, act_v, exp_v);
         end
         if (sh_ldn === 1'b0) begin
            load_cnt++;
            obs_ld.push_back({a, b, c, d});
         end
         if (line_done === 1'b1) begin
            done_cnt++;
            done_rel = rel;
         end
         if (spur > 0 && rel == spur - 1) line_start = 1'b1;
         if (spur > 0 && rel == spur)     line_start = 1'b0;
      end
      for (int w = 0; w < 60 && (mem_req || mem_pend); w++) @(negedge clk);
      vectors++;
      if (mem_req || mem_pend) begin
         miscompares++;
         $display("FAIL fetch_idle: got mem_req=%b pending=%b required both 0", mem_req, mem_pend);
      end
      vectors++;
      if (addr_log.size() - addr_idx0 != NPL / 2) begin
         miscompares++;
         $display("FAIL req_count: got %0d required %0d", addr_log.size() - addr_idx0, NPL / 2);
      end else begin
         for (int i = 0; i < NPL / 2; i++) begin
            vectors++;
            if (addr_log[addr_idx0 + i] !== AW'(base + AW'(i))) begin
               miscompares++;
               $display("FAIL req_addr[%0d]: got %h required %h", i, addr_log[addr_idx0 + i], AW'(base + AW'(i)));
            end
         end
      end
   endtask

   task automatic test_reset();
      logic [25:0] exp_v, act_v;
      clrn = 1'b0;
      @(negedge clk);
      exp_v = {1'b1, 4'h0, 1'b0, 16'h0000, 4'h0};
      act_v = {sh_ldn, a, b, c, d, mem_req, mem_addr, active, line_done, underrun, j | kn};
      vectors++;
      if (act_v !== exp_v) begin
         miscompares++;
         $display("FAIL reset_state: got %h required %h", act_v, exp_v);
      end
      model_clear();
      @(negedge clk);
      clrn = 1'b1;
   endtask

   task automatic test_fifo_push_pop();
      logic p, q;
      logic [7:0] dd;
      fq.delete();
      for (int i = 0; i < 41; i++) begin
         @(negedge clk);
         vectors++;
         if (f_count !== 2'(fq.size())) begin
            miscompares++;
            $display("FAIL fifo_count step=%0d: got %0d required %0d", i, f_count, fq.size());
         end
         if (fq.size() > 0) begin
            vectors++;
            if (f_head !== fq[0]) begin
               miscompares++;
               $display("FAIL fifo_head step=%0d: got %h required %h", i, f_head, fq[0]);
            end
         end
         if (i < 3) begin
            p = 1'b1;
            q = (i == 2);
         end else begin
            p = 1'($urandom_range(0, 1));
            q = 1'($urandom_range(0, 1));
            if (fq.size() == 2 && !q) p = 1'b0;
         end
         if (i == 40) begin p = 1'b0; q = 1'b0; end
         dd = 8'($urandom);
         f_push = p; f_pop = q; f_din = dd;
         if (q && fq.size() > 0) void'(fq.pop_front());
         if (p) fq.push_back(dd);
      end
   endtask

   task automatic test_basic_line();
      logic [3:0] want [4];
      want[0] = 4'h5; want[1] = 4'hA; want[2] = 4'hC; want[3] = 4'h3;
      ram[32'h1000] = 8'hA5;
      ram[32'h1001] = 8'h3C;
      do_line(16'h1000, 1, 0);
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (obs_ld.size() <= i || obs_ld[i] !== want[i]) begin
            miscompares++;
            $display("FAIL basic_nibble[%0d]: got %b required %b", i,
                     (obs_ld.size() > i) ? obs_ld[i] : 4'hx, want[i]);
         end
      end
      vectors++;
      if (done_rel != 20 || underrun !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_done: got done clock %0d underrun %b required 21 and 0", done_rel + 1, underrun);
      end
   endtask

   task automatic test_addr_wrap();
      do_line(16'hFFFF, 1, 0);
      vectors++;
      if (addr_log.size() < 2 || addr_log[addr_log.size() - 2] !== 16'hFFFF ||
          addr_log[addr_log.size() - 1] !== 16'h0000) begin
         miscompares++;
         $display("FAIL addr_wrap: got last addresses not FFFF,0000 (log size %0d) required FFFF then 0000",
                  addr_log.size());
      end
   endtask

   task automatic test_fast_lines();
      for (int n = 0; n < 5; n++) begin
         do_line(16'($urandom), $urandom_range(1, 2), 0);
         vectors++;
         if (underrun !== 1'b0) begin
            miscompares++;
            $display("FAIL fast_no_underrun line=%0d: got %b required 0", n, underrun);
         end
      end
   endtask

   task automatic test_slow_memory();
      do_line(16'($urandom), 9, 0);
      vectors++;
      if (obs_ld.size() < 1 || obs_ld[0] !== 4'h0) begin
         miscompares++;
         $display("FAIL slow_first_load: got %b required 0000", (obs_ld.size() > 0) ? obs_ld[0] : 4'hx);
      end
      repeat (5) @(negedge clk);
      vectors++;
      if (underrun !== 1'b1) begin
         miscompares++;
         $display("FAIL slow_sticky: got underrun %b required 1", underrun);
      end
      do_line(16'($urandom), 1, 0);
      for (int n = 0; n < 4; n++) do_line(16'($urandom), $urandom_range(1, 12), 0);
   endtask

   task automatic test_spurious_start();
      do_line(16'($urandom), 1, 6);
      vectors++;
      if (load_cnt != NPL || done_cnt != 1) begin
         miscompares++;
         $display("FAIL spurious_start: got loads %0d dones %0d required %0d and 1", load_cnt, done_cnt, NPL);
      end
   endtask

   task automatic test_reset_midline();
      int t0;
      logic [25:0] exp_v, act_v;
      lat = 9;
      @(negedge clk);
      line_base  = 16'h4000;
      line_start = 1'b1;
      @(negedge clk);
      line_start = 1'b0;
      t0 = cyc;
      for (int w = 0; w < 40 && cyc < t0 + 10; w++) @(posedge clk);
      #1;
      vectors++;
      if (mem_req !== 1'b1) begin
         miscompares++;
         $display("FAIL midline_req: got mem_req %b required 1", mem_req);
      end
      clrn = 1'b0;
      #1;
      exp_v = {1'b1, 4'h0, 1'b0, 16'h0000, 4'h0};
      act_v = {sh_ldn, a, b, c, d, mem_req, mem_addr, active, line_done, underrun, j | kn};
      vectors++;
      if (act_v !== exp_v) begin
         miscompares++;
         $display("FAIL midline_reset: got %h required %h", act_v, exp_v);
      end
      model_clear();
      repeat (2) @(negedge clk);
      clrn = 1'b1;
      do_line(16'($urandom), 1, 0);
      vectors++;
      if (underrun !== 1'b0 || load_cnt != NPL) begin
         miscompares++;
         $display("FAIL after_reset_line: got underrun %b loads %0d required 0 and %0d", underrun, load_cnt, NPL);
      end
   endtask

   initial begin
      test_reset();
      test_fifo_push_pop();
      test_basic_line();
      test_addr_wrap();
      test_fast_lines();
      test_slow_memory();
      test_spurious_start();
      test_reset_midline();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
